// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage
//   Decode/operand stage feeding the RV32I ALU. One fetched instruction (with its
//   PC and register-file read data) is accepted per valid/ready handshake, decoded,
//   and captured into a single ID/EX register. Besides ALU operands and the ALU
//   select code it produces branch/jump target, memory and writeback controls.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready is combinational)
//   in_instr, in_pc    instruction word and its PC
//   in_rs1_data/rs2    register-file data for rs1_addr/rs2_addr
//   rs1_addr/rs2_addr  combinational register-file read addresses
//   flush              kill the held beat and any incoming beat
//   out_valid/ready    downstream handshake
//   out_alu_a/b/sel    ALU operands and select {funct7[5], funct3}
//   out_rd, out_rd_we  destination register and writeback enable
//   out_is_branch, out_br_funct3, out_is_jump, out_target   control-flow info
//   out_is_load, out_is_store, out_mem_funct3, out_store_data  memory info
//   out_illegal        instruction could not be decoded
module rv32i_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [3:0]      out_alu_selectop,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_is_branch,
  output logic [2:0]      out_br_funct3,
  output logic            out_is_jump,
  output logic [XLEN-1:0] out_target,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic [2:0]      out_mem_funct3,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_illegal
);

  if (XLEN != 32) begin : g_xlen_check
    $error("rv32i_decode_stage: only XLEN=32 is supported");
  end

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] ins);
    return XLEN'($signed(ins[31:20]));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] ins);
    return XLEN'($signed({ins[31:25], ins[11:7]}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] ins);
    return XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] ins);
    return XLEN'($signed({ins[31:12], 12'b0}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] ins);
    return XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  endfunction

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd_f;

  assign opcode   = in_instr[6:0];
  assign rd_f     = in_instr[11:7];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // ---- p0: combinational decode of the incoming beat ----
  logic [XLEN-1:0] a_p0, b_p0, tgt_p0, sd_p0;
  logic [3:0]      sel_p0;
  logic [4:0]      rd_p0;
  logic [2:0]      brf3_p0, mf3_p0;
  logic            wr_p0, we_p0, br_p0, jmp_p0, ld_p0, st_p0, ill_p0;
  logic            is_shift;

  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    a_p0 = '0; b_p0 = '0; sel_p0 = '0; rd_p0 = '0; wr_p0 = 1'b0;
    br_p0 = 1'b0; brf3_p0 = '0; jmp_p0 = 1'b0; tgt_p0 = '0;
    ld_p0 = 1'b0; st_p0 = 1'b0; mf3_p0 = '0; sd_p0 = '0; ill_p0 = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          a_p0 = in_rs1_data; b_p0 = in_rs2_data; sel_p0 = {f7[5], f3};
          rd_p0 = rd_f; wr_p0 = 1'b1;
        end else ill_p0 = 1'b1;
      end
      OPC_OPIMM: begin
        if ((f3 == 3'b001 && f7 != 7'h00) ||
            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) begin
          ill_p0 = 1'b1;
        end else begin
          a_p0 = in_rs1_data;
          // Shifts carry only the shamt so imm bit 30 does not leak into b.
          b_p0 = is_shift ? XLEN'(in_instr[24:20]) : imm_i(in_instr);
          // Imm bit 30 selects SRA only; ADDI etc. must never become SUB.
          sel_p0 = {(f3 == 3'b101) & f7[5], f3};
          rd_p0 = rd_f; wr_p0 = 1'b1;
        end
      end
      OPC_LUI: begin
        b_p0 = imm_u(in_instr); rd_p0 = rd_f; wr_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        a_p0 = in_pc; b_p0 = imm_u(in_instr); rd_p0 = rd_f; wr_p0 = 1'b1;
      end
      OPC_JAL: begin
        a_p0 = in_pc; b_p0 = XLEN'(4); rd_p0 = rd_f; wr_p0 = 1'b1;
        jmp_p0 = 1'b1; tgt_p0 = in_pc + imm_j(in_instr);
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          a_p0 = in_pc; b_p0 = XLEN'(4); rd_p0 = rd_f; wr_p0 = 1'b1;
          jmp_p0 = 1'b1;
          tgt_p0 = (in_rs1_data + imm_i(in_instr)) & ~XLEN'(1);
        end else ill_p0 = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          // ALU runs a subtract; the branch unit picks the flag via br_funct3.
          a_p0 = in_rs1_data; b_p0 = in_rs2_data; sel_p0 = 4'b1000;
          br_p0 = 1'b1; brf3_p0 = f3; tgt_p0 = in_pc + imm_b(in_instr);
        end else ill_p0 = 1'b1;
      end
      OPC_LOAD: begin
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
          a_p0 = in_rs1_data; b_p0 = imm_i(in_instr); rd_p0 = rd_f; wr_p0 = 1'b1;
          ld_p0 = 1'b1; mf3_p0 = f3;
        end else ill_p0 = 1'b1;
      end
      OPC_STORE: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
          a_p0 = in_rs1_data; b_p0 = imm_s(in_instr);
          st_p0 = 1'b1; mf3_p0 = f3; sd_p0 = in_rs2_data;
        end else ill_p0 = 1'b1;
      end
      OPC_FENCE: ;
      default: ill_p0 = 1'b1;
    endcase
  end

  assign we_p0 = wr_p0 & (rd_p0 != 5'd0);

  // ---- p1: ID/EX register ----
  logic            vld_p1;
  logic            xfer;
  logic [XLEN-1:0] a_p1, b_p1, tgt_p1, sd_p1;
  logic [3:0]      sel_p1;
  logic [4:0]      rd_p1;
  logic [2:0]      brf3_p1, mf3_p1;
  logic            we_p1, br_p1, jmp_p1, ld_p1, st_p1, ill_p1;

  assign in_ready = ~vld_p1 | out_ready | flush;
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst)            vld_p1 <= 1'b0;
    else if (flush)     vld_p1 <= 1'b0;
    else if (xfer)      vld_p1 <= 1'b1;
    else if (out_ready) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1 <= '0; b_p1 <= '0; sel_p1 <= '0; rd_p1 <= '0; we_p1 <= 1'b0;
      br_p1 <= 1'b0; brf3_p1 <= '0; jmp_p1 <= 1'b0; tgt_p1 <= '0;
      ld_p1 <= 1'b0; st_p1 <= 1'b0; mf3_p1 <= '0; sd_p1 <= '0; ill_p1 <= 1'b0;
    end else if (xfer && !flush) begin
      a_p1 <= a_p0; b_p1 <= b_p0; sel_p1 <= sel_p0; rd_p1 <= rd_p0; we_p1 <= we_p0;
      br_p1 <= br_p0; brf3_p1 <= brf3_p0; jmp_p1 <= jmp_p0; tgt_p1 <= tgt_p0;
      ld_p1 <= ld_p0; st_p1 <= st_p0; mf3_p1 <= mf3_p0; sd_p1 <= sd_p0; ill_p1 <= ill_p0;
    end
  end

  assign out_valid        = vld_p1;
  assign out_alu_a        = a_p1;
  assign out_alu_b        = b_p1;
  assign out_alu_selectop = sel_p1;
  assign out_rd           = rd_p1;
  assign out_rd_we        = we_p1;
  assign out_is_branch    = br_p1;
  assign out_br_funct3    = brf3_p1;
  assign out_is_jump      = jmp_p1;
  assign out_target       = tgt_p1;
  assign out_is_load      = ld_p1;
  assign out_is_store     = st_p1;
  assign out_mem_funct3   = mf3_p1;
  assign out_store_data   = sd_p1;
  assign out_illegal      = ill_p1;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
module tb_rv32i_decode_stage;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [31:0] out_alu_a, out_alu_b, out_target, out_store_data;
  logic [3:0]  out_alu_selectop;
  logic [2:0]  out_br_funct3, out_mem_funct3;
  logic        out_rd_we, out_is_branch, out_is_jump, out_is_load, out_is_store, out_illegal;

  rv32i_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_selectop(out_alu_selectop),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_branch(out_is_branch),
    .out_br_funct3(out_br_funct3), .out_is_jump(out_is_jump), .out_target(out_target),
    .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_mem_funct3(out_mem_funct3), .out_store_data(out_store_data),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: a b sel rd we br brf3 jmp target ld st mf3 store_data illegal
  logic [148:0] act;
  assign act = {out_alu_a, out_alu_b, out_alu_selectop, out_rd, out_rd_we,
                out_is_branch, out_br_funct3, out_is_jump, out_target,
                out_is_load, out_is_store, out_mem_funct3, out_store_data, out_illegal};

  function automatic logic [148:0] pk(input logic [31:0] a, input logic [31:0] b,
      input logic [3:0] sel, input logic [4:0] rd, input logic we, input logic br,
      input logic [2:0] brf3, input logic jmp, input logic [31:0] tgt, input logic ld,
      input logic st, input logic [2:0] mf3, input logic [31:0] sd, input logic ill);
    return {a, b, sel, rd, we, br, brf3, jmp, tgt, ld, st, mf3, sd, ill};
  endfunction

  typedef struct {
    string        name;
    logic [31:0]  instr, pc, rs1d, rs2d;
    logic [148:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [148:0] got, input logic [148:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic addv(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [148:0] e);
    vec_t v;
    v.name = nm; v.instr = ins; v.pc = pc; v.rs1d = r1; v.rs2d = r2; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_instr = v.instr; in_pc = v.pc; in_rs1_data = v.rs1d; in_rs2_data = v.rs2d;
  endtask

  initial begin
    addv("add",   32'h002081B3, 32'h0,   32'd5, 32'd7, pk(5, 7, 4'h0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("sub",   32'h402081B3, 32'h0,   32'd5, 32'd7, pk(5, 7, 4'h8, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("addi",  32'hFFF00093, 32'h0,   32'h10, 32'h0, pk(32'h10, 32'hFFFFFFFF, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("srai",  32'h4040D093, 32'h0,   32'h80000000, 32'h0, pk(32'h80000000, 4, 4'hD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("srli",  32'h01F0D093, 32'h0,   32'h80000000, 32'h0, pk(32'h80000000, 31, 4'h5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("jal",   32'h008000EF, 32'h100, 32'h0, 32'h0, pk(32'h100, 4, 4'h0, 1, 1, 0, 0, 1, 32'h108, 0, 0, 0, 0, 0));
    addv("lui",   32'h123452B7, 32'h50,  32'h99, 32'h0, pk(0, 32'h12345000, 4'h0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("auipc", 32'h00001297, 32'h200, 32'h0, 32'h0, pk(32'h200, 32'h1000, 4'h0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("bge",   32'hFE20D8E3, 32'h300, 32'hFFFFFFFF, 32'd1, pk(32'hFFFFFFFF, 1, 4'h8, 0, 0, 1, 5, 0, 32'h2F0, 0, 0, 0, 0, 0));
    addv("lw",    32'hFFC0A303, 32'h0,   32'h1000, 32'h55, pk(32'h1000, 32'hFFFFFFFC, 4'h0, 6, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    addv("sw",    32'h0020A623, 32'h0,   32'h2000, 32'hDEADBEEF, pk(32'h2000, 12, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'hDEADBEEF, 0));
    addv("jalr",  32'h005080E7, 32'h400, 32'h1000, 32'h0, pk(32'h400, 4, 4'h0, 1, 1, 0, 0, 1, 32'h1004, 0, 0, 0, 0, 0));
    addv("ill7f", 32'h000002FF, 32'h0,   32'd5, 32'd7, pk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    addv("add_x0",32'h00208033, 32'h0,   32'd5, 32'd7, pk(5, 7, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("mul",   32'h022081B3, 32'h0,   32'd5, 32'd7, pk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    addv("fence", 32'h0FF0000F, 32'h0,   32'd5, 32'd7, pk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("slli_b",32'h40109093, 32'h0,   32'd5, 32'd7, pk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    addv("br010", 32'h00002063, 32'h0,   32'd5, 32'd7, pk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 149'(out_valid), 149'(0));
    chk("rst_in_ready", 149'(in_ready), 149'(1));
    chk("rst_payload", act, '0);
    rst = 1'b0;

    // Back-to-back table vectors, one per cycle.
    drive(vecs[0]);
    #1;
    chk("rs_addrs", 149'({rs1_addr, rs2_addr}), 149'({5'd1, 5'd2}));
    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_valid"}, 149'(out_valid), 149'(1));
      chk(vecs[i].name, act, vecs[i].exp);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", 149'(out_valid), 149'(0));

    // Stall: ADD held for three cycles while SUB waits.
    drive(vecs[0]); in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_first", act, vecs[0].exp);
    drive(vecs[1]); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 149'(in_ready), 149'(0));
      @(posedge clk);
      #1;
      chk("stall_valid", 149'(out_valid), 149'(1));
      chk("stall_payload", act, vecs[0].exp);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 149'(in_ready), 149'(1));
    @(posedge clk);
    #1;
    chk("unstall_next", act, vecs[1].exp);
    chk("unstall_valid", 149'(out_valid), 149'(1));

    // Flush with a held beat and a simultaneous incoming beat.
    out_ready = 1'b0; drive(vecs[2]); in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", 149'(in_ready), 149'(1));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 149'(out_valid), 149'(0));
    chk("flush_no_load", act, vecs[1].exp);

    // Reset in the middle of a stall.
    out_ready = 1'b1; drive(vecs[3]); in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 149'(out_valid), 149'(1));
    chk("pre_rst_payload", act, vecs[3].exp);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 149'(out_valid), 149'(0));
    chk("midrst_payload", act, '0);
    chk("midrst_in_ready", 149'(in_ready), 149'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
